mux_req_bridge_rr: RTL and testbench
====================================

Name: mux_req_bridge_rr

Overview:
- N-channel request multiplexer for the XBAR bridge path. Merges N_CH initiator request channels onto one target request port.
- Replaces fixed 2-way toggle arbitration with a rotating-priority round-robin arbiter.
- Adds a lock mode that holds the bus for one initiator across consecutive transfers (atomics/bursts), with an idle-timeout release.
- Request path stays combinational (zero latency). Sequential state is the priority pointer, the lock FSM and the idle counter.

Parameters:
- N_CH, 4, number of request channels (>=2; need not be a power of 2)
- ID_WIDTH, 20, transaction ID width
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write-data width
- AUX_WIDTH, 6, auxiliary sideband width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- TAG_WIDTH, DATA_WIDTH/8, write-tag width
- LOCK_IDLE_MAX, 16, consecutive owner-idle cycles before a lock is force-released (>=1)
- CH_W, $clog2(N_CH), channel index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  N_CH  per-channel request
- data_lock_i  in  N_CH  per-channel lock request, sampled with req
- data_add_i  in  N_CH x ADDR_WIDTH  address
- data_wen_i  in  N_CH  write enable (active-low: 0 = write)
- data_wdata_i  in  N_CH x DATA_WIDTH  write data
- data_wtag_i  in  N_CH x TAG_WIDTH  write tag
- data_be_i  in  N_CH x BE_WIDTH  byte enable
- data_ID_i  in  N_CH x ID_WIDTH  transaction ID
- data_aux_i  in  N_CH x AUX_WIDTH  sideband
- data_gnt_o  out  N_CH  per-channel grant (one-hot or zero)
- data_req_o  out  1  merged request
- data_add_o / data_wen_o / data_wdata_o / data_wtag_o / data_be_o / data_ID_o / data_aux_o  out  matching widths  selected channel payload
- data_gnt_i  in  1  target grant
- data_sel_o  out  CH_W  index of the currently selected channel (for response routing/debug)

Behaviour:
- Reset: one clock (clk); asynchronous, active-low reset (rst_n). While rst_n=0: rr_ptr=0, state=ARB, owner=0, idle_cnt=0.
  - Outputs remain combinational functions of the inputs and of this reset state. With no request: data_req_o=0, data_gnt_o=0, data_sel_o=0, payload = channel 0.
- Eligible set:
  - ARB: all channels with req=1.
  - LOCKED: only the owner, and only if req[owner]=1.
- Selection: first eligible channel scanning rr_ptr, rr_ptr+1, ... with wrap modulo N_CH. In LOCKED, sel=owner. With no eligible channel, sel=rr_ptr in ARB and owner in LOCKED.
- data_req_o = OR of the eligible set.
  - In LOCKED, other channels' requests are masked.
- data_gnt_o[sel] = eligible & data_gnt_i. All other grant bits are 0. A transfer is accepted when data_req_o & data_gnt_i.
- Payload muxed by sel, same cycle (no pipeline stage).
- Pointer update:
  - On an accepted transfer in ARB with lock=0: rr_ptr <= (sel+1) mod N_CH. Wrap from N_CH-1 goes to 0, including non-power-of-2 N_CH.
  - While LOCKED, rr_ptr holds.
- FSM:
  - ARB -> LOCKED: accepted transfer with data_lock_i[sel]=1. owner <= sel, idle_cnt <= 0. rr_ptr not updated.
  - LOCKED -> LOCKED: accepted owner transfer with lock=1. idle_cnt <= 0.
  - LOCKED -> ARB on either of:
    - accepted owner transfer with lock=0;
    - idle_cnt reaching LOCK_IDLE_MAX-1 while req[owner]=0.
    - On both exits: rr_ptr <= (owner+1) mod N_CH, idle_cnt <= 0.
  - idle_cnt: increments each LOCKED cycle with req[owner]=0. Clears on any owner request cycle. Saturates; never wraps.
- Simultaneous events: a timeout and a new owner request in the same cycle resolve in favour of the request (no release). data_gnt_i=0 never changes state.
- Reset mid-lock returns to ARB immediately; no grant is asserted during reset.
- Requesters must hold req and payload stable until granted. The block does not check this.

Decomposition:
- Package mux_req_bridge_pkg:
  - lock_state_e {ARB, LOCKED}
  - rr_next_idx function: (idx+1) mod n, wrap-safe
- Sub-module rr_prio_pick: combinational, parameter N_CH. Inputs: eligible vector, rr_ptr. Outputs: sel index, found flag. Reusable by other xbar bridges.
- Top holds the FSM, counter, pointer and payload mux.

Test Plan:
- N_CH=4, all req=1 continuously, gnt_i=1, lock=0 -> grants cycle ch0,1,2,3,0; each data_ID_o equals the granted channel's ID.
- req={ch1,ch3}, gnt_i=1, rr_ptr=2 -> ch3 granted, then ch1, then ch3; ch0/ch2 gnt stay 0.
- ch2 req with lock=1 for 3 transfers then lock=0, ch0 req=1 throughout -> ch2 gets 4 consecutive grants, ch0 masked (data_req_o follows ch2 only), ch0 granted next cycle, rr_ptr=3 after release.
- Lock owner ch1 drops req after locking, LOCK_IDLE_MAX=16, ch0 req=1 -> data_req_o=0 for 16 cycles, release, ch0 granted on cycle 17.
- All req=1, gnt_i=0 for 10 cycles -> data_gnt_o=0, sel constant, rr_ptr unchanged. Then gnt_i=1 -> the same channel is granted.
- rst_n asserted while LOCKED with ch2 owner -> gnt_o=0 immediately. After release, first grant follows rr_ptr=0.

Source files
------------

// File: rtl/mux_req_bridge_pkg.sv
// Shared types and helpers for the round-robin request bridge.
//   lock_state_e : arbitration mode (ARB = free round robin, LOCKED = bus held by one owner)
//   rr_next_idx  : (idx + 1) mod n, safe for any n >= 1 (no power-of-2 assumption)
package mux_req_bridge_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Successor index with explicit wrap so non-power-of-2 channel counts work.
  function automatic logic [31:0] rr_next_idx(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mux_req_bridge_rr_prio_pick.sv
// Rotating-priority picker: returns the first set bit of 'eligible' scanning
// ptr, ptr+1, ... with wrap modulo N_CH.
//   eligible : N_CH request vector
//   ptr      : highest-priority index this cycle
//   sel      : chosen index (ptr when nothing is eligible)
//   found    : at least one eligible bit was set
module rr_prio_pick #(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] sel,
  output logic            found
);

  logic [CH_W:0]   idx_s;
  logic [CH_W-1:0] wrap_idx_s;

  // Priority scan starting at ptr; one extra bit on idx_s holds ptr+i before the wrap.
  always_comb begin
    sel        = ptr;
    found      = 1'b0;
    idx_s      = '0;
    wrap_idx_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx_s = {1'b0, ptr} + (CH_W+1)'(i);
      if (idx_s >= (CH_W+1)'(N_CH)) begin
        idx_s = idx_s - (CH_W+1)'(N_CH);
      end else begin
        idx_s = idx_s;
      end
      wrap_idx_s = idx_s[CH_W-1:0];
      if (!found && eligible[wrap_idx_s]) begin
        found = 1'b1;
        sel   = wrap_idx_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mux_req_bridge_rr.sv
// N-channel request multiplexer with round-robin arbitration and a lock mode.
// The request/grant/payload path is purely combinational; only the priority
// pointer, the lock FSM (state/owner) and the owner-idle counter are registered.
//   clk, rst_n                : clock, asynchronous active-low reset
//   data_req_i/data_lock_i    : per-channel request and lock-hold request
//   data_*_i                  : per-channel payload (addr, wen, wdata, wtag, be, ID, aux)
//   data_gnt_o                : per-channel grant, one-hot or zero
//   data_req_o, data_*_o      : merged request and selected payload toward the target
//   data_gnt_i                : target grant
//   data_sel_o                : index of the currently selected channel
module mux_req_bridge_rr
  import mux_req_bridge_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int ID_WIDTH      = 20,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int AUX_WIDTH     = 6,
  parameter int BE_WIDTH      = DATA_WIDTH/8,
  parameter int TAG_WIDTH     = DATA_WIDTH/8,
  parameter int LOCK_IDLE_MAX = 16,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_CH-1:0]                     data_req_i,
  input  logic [N_CH-1:0]                     data_lock_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]     data_add_i,
  input  logic [N_CH-1:0]                     data_wen_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [N_CH-1:0][TAG_WIDTH-1:0]      data_wtag_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]       data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]       data_ID_i,
  input  logic [N_CH-1:0][AUX_WIDTH-1:0]      data_aux_i,
  output logic [N_CH-1:0]                     data_gnt_o,
  output logic                                data_req_o,
  output logic [ADDR_WIDTH-1:0]               data_add_o,
  output logic                                data_wen_o,
  output logic [DATA_WIDTH-1:0]               data_wdata_o,
  output logic [TAG_WIDTH-1:0]                data_wtag_o,
  output logic [BE_WIDTH-1:0]                 data_be_o,
  output logic [ID_WIDTH-1:0]                 data_ID_o,
  output logic [AUX_WIDTH-1:0]                data_aux_o,
  input  logic                                data_gnt_i,
  output logic [CH_W-1:0]                     data_sel_o
);

  localparam int IDLE_W = $clog2(LOCK_IDLE_MAX + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_IDLE_MAX - 1);

  lock_state_e       state_r, state_s;
  logic [CH_W-1:0]   owner_r, owner_s;
  logic [CH_W-1:0]   ptr_r, ptr_s;
  logic [IDLE_W-1:0] idle_r, idle_s;

  logic [N_CH-1:0]   eligible_s;
  logic [CH_W-1:0]   pick_sel_s, sel_s;
  logic              pick_found_s, found_s, accept_s;

  // Eligible set: everyone requesting in ARB, only the owner while LOCKED.
  always_comb begin
    eligible_s = '0;
    case (state_r)
      ARB:     eligible_s = data_req_i;
      LOCKED:  eligible_s[owner_r] = data_req_i[owner_r];
      default: eligible_s = '0;
    endcase
  end

  rr_prio_pick #(.N_CH(N_CH)) u_pick (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .sel      (pick_sel_s),
    .found    (pick_found_s)
  );

  // Selection: the locked owner always holds the mux, even while idle.
  always_comb begin
    sel_s   = ptr_r;
    found_s = 1'b0;
    case (state_r)
      ARB: begin
        sel_s   = pick_sel_s;
        found_s = pick_found_s;
      end
      LOCKED: begin
        sel_s   = owner_r;
        found_s = data_req_i[owner_r];
      end
      default: begin
        sel_s   = ptr_r;
        found_s = 1'b0;
      end
    endcase
  end

  assign data_req_o = found_s;
  assign accept_s   = found_s & data_gnt_i;
  assign data_sel_o = sel_s;

  // Grant fan-out; suppressed while rst_n is low so no transfer is acknowledged in reset.
  always_comb begin
    data_gnt_o = '0;
    if (rst_n && accept_s) begin
      data_gnt_o[sel_s] = 1'b1;
    end else begin
      data_gnt_o = '0;
    end
  end

  assign data_add_o   = data_add_i[sel_s];
  assign data_wen_o   = data_wen_i[sel_s];
  assign data_wdata_o = data_wdata_i[sel_s];
  assign data_wtag_o  = data_wtag_i[sel_s];
  assign data_be_o    = data_be_i[sel_s];
  assign data_ID_o    = data_ID_i[sel_s];
  assign data_aux_o   = data_aux_i[sel_s];

  // Lock FSM, pointer and idle-counter next-state logic.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    idle_s  = idle_r;
    case (state_r)
      ARB: begin
        if (accept_s && data_lock_i[sel_s]) begin
          // Pointer stays put on lock entry; it advances past the owner on release.
          state_s = LOCKED;
          owner_s = sel_s;
          idle_s  = '0;
        end else if (accept_s) begin
          ptr_s = CH_W'(rr_next_idx(32'(sel_s), N_CH));
        end else begin
          state_s = ARB;
        end
      end
      LOCKED: begin
        if (data_req_i[owner_r]) begin
          // An owner request always beats a coinciding timeout.
          idle_s = '0;
          if (accept_s && !data_lock_i[owner_r]) begin
            state_s = ARB;
            ptr_s   = CH_W'(rr_next_idx(32'(owner_r), N_CH));
          end else begin
            state_s = LOCKED;
          end
        end else if (idle_r >= IDLE_LAST) begin
          state_s = ARB;
          ptr_s   = CH_W'(rr_next_idx(32'(owner_r), N_CH));
          idle_s  = '0;
        end else begin
          idle_s = idle_r + IDLE_W'(1);
        end
      end
      default: begin
        state_s = ARB;
        owner_s = '0;
        ptr_s   = '0;
        idle_s  = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      owner_r <= '0;
      ptr_r   <= '0;
      idle_r  <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      idle_r  <= idle_s;
    end
  end

endmodule

// File: tb/tb_mux_req_bridge_rr.sv
module tb_mux_req_bridge_rr;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    data_req_i, data_lock_i, data_wen_i;
  logic [N-1:0][31:0] data_add_i, data_wdata_i;
  logic [N-1:0][3:0]  data_wtag_i, data_be_i;
  logic [N-1:0][19:0] data_ID_i;
  logic [N-1:0][5:0]  data_aux_i;
  logic [N-1:0]    data_gnt_o;
  logic            data_req_o, data_wen_o, data_gnt_i;
  logic [31:0]     data_add_o, data_wdata_o;
  logic [3:0]      data_wtag_o, data_be_o;
  logic [19:0]     data_ID_o;
  logic [5:0]      data_aux_o;
  logic [1:0]      data_sel_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  mux_req_bridge_rr dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_lock_i(data_lock_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_wtag_i(data_wtag_i),
    .data_be_i(data_be_i), .data_ID_i(data_ID_i), .data_aux_i(data_aux_i),
    .data_gnt_o(data_gnt_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
    .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_wtag_o(data_wtag_o),
    .data_be_o(data_be_o), .data_ID_o(data_ID_o), .data_aux_o(data_aux_o),
    .data_gnt_i(data_gnt_i), .data_sel_o(data_sel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] gvec(input int c);
    logic [N-1:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [19:0] exp_id(input int c);
    return 20'h0A000 + 20'(c * 17);
  endfunction

  function automatic logic [31:0] exp_add(input int c);
    return 32'hC000_0000 + 32'(c * 256);
  endfunction

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock, input logic gnt);
    data_req_i  = req;
    data_lock_i = lock;
    data_gnt_i  = gnt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
    #4;
    checks++;
    if (data_req_o !== 1'b0 || data_gnt_o !== 4'b0000 || data_sel_o !== 2'd0 || data_ID_o !== exp_id(0)) begin
      errors++;
      $display("FAIL reset_state req=%b gnt=%b sel=%0d id=%h, want req=0 gnt=0000 sel=0 id=%h",
               data_req_o, data_gnt_o, data_sel_o, data_ID_o, exp_id(0));
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_round_robin();
    int exps[5] = '{0, 1, 2, 3, 0};
    int e;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0000, 1'b1);
      exp_q.push_back(exps[k]);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e) || data_ID_o !== exp_id(e) || data_add_o !== exp_add(e)) begin
        errors++;
        $display("FAIL rr_cycle k=%0d gnt=%b id=%h add=%h, want gnt=%b id=%h add=%h",
                 k, data_gnt_o, data_ID_o, data_add_o, gvec(e), exp_id(e), exp_add(e));
      end
      next_cycle();
    end
  endtask

  task automatic test_sparse();
    // first row advances the pointer to 2, then ch1/ch3 alternate, then an idle probe of the pointer
    logic [N-1:0] reqs[5] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    int exps[5] = '{1, 3, 1, 3, -1};
    int e;
    for (int k = 0; k < 5; k++) begin
      drive(reqs[k], 4'b0000, 1'b1);
      exp_q.push_back(exps[k]);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e)) begin
        errors++;
        $display("FAIL sparse_gnt k=%0d got=%b want=%b", k, data_gnt_o, gvec(e));
      end
      if (e < 0) begin
        checks++;
        if (data_sel_o !== 2'd0 || data_req_o !== 1'b0) begin
          errors++;
          $display("FAIL sparse_ptr sel=%0d req=%b, want sel=0 req=0", data_sel_o, data_req_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    // row 0 sets ptr=2; ch2 locks for 3 transfers and unlocks on the 4th; ch0 keeps requesting
    logic [N-1:0] reqs[7]  = '{4'b0010, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0001};
    logic [N-1:0] locks[7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    int exps[7] = '{1, 2, 2, 2, 2, -1, 0};
    int e;
    for (int k = 0; k < 7; k++) begin
      drive(reqs[k], locks[k], 1'b1);
      exp_q.push_back(exps[k]);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e) || (e >= 0 && data_ID_o !== exp_id(e))) begin
        errors++;
        $display("FAIL lock_gnt k=%0d gnt=%b id=%h, want gnt=%b id=%h",
                 k, data_gnt_o, data_ID_o, gvec(e), exp_id(e));
      end
      if (e < 0) begin
        checks++;
        if (data_sel_o !== 2'd3) begin
          errors++;
          $display("FAIL lock_release_ptr sel=%0d want 3", data_sel_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    int e;
    // pointer is 1 here: ch1 takes the lock
    drive(4'b0010, 4'b0010, 1'b1);
    exp_q.push_back(1);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (data_gnt_o !== gvec(e)) begin
      errors++;
      $display("FAIL timeout_lock got=%b want=%b", data_gnt_o, gvec(e));
    end
    next_cycle();
    for (int k = 1; k <= 17; k++) begin
      drive(4'b0001, 4'b0000, 1'b1);
      exp_q.push_back((k == 17) ? 0 : -1);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e) || data_req_o !== (e >= 0) || data_sel_o !== ((e >= 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL timeout_cycle k=%0d gnt=%b req=%b sel=%0d, want gnt=%b req=%b",
                 k, data_gnt_o, data_req_o, data_sel_o, gvec(e), (e >= 0));
      end
      next_cycle();
    end
  endtask

  task automatic test_no_gnt();
    int e;
    // pointer is 1 here
    for (int k = 0; k < 11; k++) begin
      drive(4'b1111, 4'b0000, (k == 10));
      exp_q.push_back((k == 10) ? 1 : -1);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e) || data_sel_o !== 2'd1 || data_req_o !== 1'b1) begin
        errors++;
        $display("FAIL no_gnt k=%0d gnt=%b sel=%0d req=%b, want gnt=%b sel=1 req=1",
                 k, data_gnt_o, data_sel_o, data_req_o, gvec(e));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_lock();
    int e;
    // pointer is 2 here: ch2 takes the lock
    drive(4'b0100, 4'b0100, 1'b1);
    exp_q.push_back(2);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (data_gnt_o !== gvec(e)) begin
      errors++;
      $display("FAIL rstlock_enter got=%b want=%b", data_gnt_o, gvec(e));
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL rstlock_gnt got=%b want=0000", data_gnt_o);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(4'b1111, 4'b0000, 1'b1);
      exp_q.push_back(k);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (data_gnt_o !== gvec(e) || data_ID_o !== exp_id(e)) begin
        errors++;
        $display("FAIL rstlock_after k=%0d gnt=%b id=%h, want gnt=%b id=%h",
                 k, data_gnt_o, data_ID_o, gvec(e), exp_id(e));
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      data_ID_i[i]    = exp_id(i);
      data_add_i[i]   = exp_add(i);
      data_wdata_i[i] = 32'h5A5A_0000 + 32'(i);
      data_wtag_i[i]  = 4'(i);
      data_be_i[i]    = 4'hF;
      data_aux_i[i]   = 6'(i + 8);
    end
    data_wen_i = 4'b0101;
    #1;
    test_reset();
    test_round_robin();
    test_sparse();
    test_lock();
    test_timeout();
    test_no_gnt();
    test_reset_mid_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
